mul_sequencer: RTL and testbench

Multi-cycle unsigned multiply controller for the integer datapath. The decoder issues the arithmetic `mul` opcode with no single-cycle register write. This block accepts the operands and sequences a shift-add multiply over WIDTH cycles, stalling issue while it runs. It then shares the register-file write port with the main pipeline to retire the low word.

---
 rtl/mul_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mul_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//
// Purpose:
//   Multi-cycle unsigned shift-add multiplier controller. A `mul` issued by
//   decode is accepted in IDLE, sequenced one multiplier bit per cycle in RUN,
//   and the low word of the product is retired through the register-file write
//   port in WB. The main pipeline has priority on that write port, so WB holds
//   for as long as pipe_wr_req is asserted.
//
// Parameters:
//   WIDTH        operand width (default 32)
//   REG_ADDR_W   register-file address width (default 5)
//
// Ports:
//   clk          in   single clock, all state updates on the rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   issue strobe, sampled only in IDLE
//   op_a         in   multiplicand, sampled with start
//   op_b         in   multiplier, sampled with start
//   rd           in   destination register, sampled with start
//   pipe_wr_req  in   main pipeline owns the write port this cycle
//   busy         out  stall to fetch/decode (RUN or WB)
//   done         out  one-cycle pulse in the cycle the result is written
//   wb_en        out  register-file write enable
//   wb_addr      out  latched rd
//   wb_data      out  low WIDTH bits of the product
//   product_hi   out  high WIDTH bits of the last completed product
//
// Build option:
//   MUL_EARLY_TERM_EN  when defined, RUN finishes as soon as the remaining
//                      multiplier bits are all zero; the pending shifts are
//                      applied in one step by a barrel shifter. When not
//                      defined RUN always lasts WIDTH cycles and no shifter
//                      exists.
// -----------------------------------------------------------------------------
module mul_sequencer #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      op_a,
    input  logic [WIDTH-1:0]      op_b,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  pipe_wr_req,
    output logic                  busy,
    output logic                  done,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]      wb_data,
    output logic [WIDTH-1:0]      product_hi
);

    // count must be able to hold WIDTH itself (used as a shift distance base)
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    // {hi, lo}: lo initially holds the multiplier and is consumed from bit 0
    // while finished product bits shift in from the top.
    logic [2*WIDTH-1:0]    prod_q, prod_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]      hi_q, hi_d;

    logic [WIDTH:0]        sum;
    logic [2*WIDTH-1:0]    step_prod;

`ifdef MUL_EARLY_TERM_EN
    logic [WIDTH-1:0]      b_rem_q, b_rem_d;
    logic [CNT_W-1:0]      shamt;
`endif

    // One shift-add step: add the multiplicand to the high half when the
    // current multiplier bit is set, keep the carry, then shift right.
    always_comb begin
        sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
        step_prod = {sum, prod_q[WIDTH-1:1]};
    end

`ifdef MUL_EARLY_TERM_EN
    // Remaining steps would only shift zeros through, so do them at once.
    assign shamt = WIDTH_CNT - count_q;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        rd_d    = rd_q;
        hi_d    = hi_q;
`ifdef MUL_EARLY_TERM_EN
        b_rem_d = b_rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    prod_d  = {{WIDTH{1'b0}}, op_b};
                    rd_d    = rd;
                    count_d = '0;
`ifdef MUL_EARLY_TERM_EN
                    b_rem_d = op_b;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef MUL_EARLY_TERM_EN
                if (b_rem_q == '0) begin
                    prod_d  = prod_q >> shamt;
                    state_d = ST_WB;
                end else
`endif
                begin
                    prod_d  = step_prod;
                    count_d = count_q + CNT_W'(1);
`ifdef MUL_EARLY_TERM_EN
                    b_rem_d = b_rem_q >> 1;
`endif
                    if (count_q == LAST_CNT) begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                // The pipeline keeps the write port while it asks for it;
                // prod_q and rd_q are untouched so the write data stays stable.
                if (!pipe_wr_req) begin
                    hi_d    = prod_q[2*WIDTH-1:WIDTH];
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            rd_q    <= '0;
            hi_q    <= '0;
`ifdef MUL_EARLY_TERM_EN
            b_rem_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            rd_q    <= rd_d;
            hi_q    <= hi_d;
`ifdef MUL_EARLY_TERM_EN
            b_rem_q <= b_rem_d;
`endif
        end
    end

    // busy depends on registered state only; wb_en is gated by pipe_wr_req so
    // the two writers can never drive the port in the same cycle.
    assign busy       = (state_q != ST_IDLE);
    assign wb_en      = (state_q == ST_WB) && !pipe_wr_req;
    assign done       = wb_en;
    assign wb_addr    = rd_q;
    assign wb_data    = prod_q[WIDTH-1:0];
    assign product_hi = hi_q;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [AW-1:0]    rd;
    logic             pipe_wr_req;
    logic             busy;
    logic             done;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic [WIDTH-1:0] product_hi;

    mul_sequencer #(.WIDTH(WIDTH), .REG_ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .rd         (rd),
        .pipe_wr_req(pipe_wr_req),
        .busy       (busy),
        .done       (done),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .product_hi (product_hi)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        int               run;
    } exp_t;

    exp_t exp_q[$];
    bit   pipe_rand = 1'b0;

    // Number of RUN cycles the operation should take.
    function automatic int model_run(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) n = i + 1;
        return (n + 1 > WIDTH) ? WIDTH : n + 1;
`else
        return WIDTH;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t             cur;
    bit               pend   = 1'b0;
    int               cur_s  = 0;
    bit               hi_chk = 1'b0;
    logic [WIDTH-1:0] hi_exp;

    always @(negedge clk) begin
        bit eb;
        bit ed;
        bit in_wb;
        if (hi_chk) begin
            check("product_hi", product_hi, hi_exp);
            hi_chk = 1'b0;
        end
        check("wb_en_and_pipe", wb_en & pipe_wr_req, 0);
        check("done_vs_wb_en", done, wb_en);
        in_wb = pend && (cyc >= cur_s + cur.run);
        eb    = pend && (cyc >= cur_s);
        ed    = in_wb && !pipe_wr_req;
        check("busy", busy, eb);
        check("done", done, ed);
        if (in_wb) begin
            check("wb_data", wb_data, cur.lo);
            check("wb_addr", wb_addr, cur.addr);
        end
        if (ed) begin
            $display("txn rd=%0d lo=%h hi=%h latency=%0d cycle=%0d",
                     wb_addr, wb_data, cur.hi, cyc - cur_s + 1, cyc);
            hi_exp = cur.hi;
            hi_chk = 1'b1;
            pend   = 1'b0;
        end
        if (!rst_n) begin
            pend   = 1'b0;
            hi_chk = 1'b0;
        end else if (start && !busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL accept: start accepted with no issued operation (cycle %0d)", cyc);
            end else begin
                cur   = exp_q.pop_front();
                cur_s = cyc + 1;
                pend  = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (pipe_rand) pipe_wr_req = ($urandom_range(0, 2) == 0);
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [AW-1:0] r);
        exp_t             e;
        logic [63:0]      p;
        p      = 64'(a) * 64'(b);
        e.addr = r;
        e.lo   = p[31:0];
        e.hi   = p[63:32];
        e.run  = model_run(b);
        exp_q.push_back(e);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        rd    = r;
        step();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        rd    = AW'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wb_en"}, wb_en, 0);
        check({tag, "_wb_addr"}, wb_addr, 0);
        check({tag, "_wb_data"}, wb_data, 0);
        check({tag, "_product_hi"}, product_hi, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               r;
        rst_n       = 1'b0;
        start       = 1'b0;
        op_a        = '0;
        op_b        = '0;
        rd          = '0;
        pipe_wr_req = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        check_zero("reset");

        // basic product and all-ones corner
        issue(32'd7, 32'd6, 5'd3);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17);
        wait_idle();

        // write port held by the pipeline for the first three WB cycles
        issue(32'd7, 32'd6, 5'd9);
        r = model_run(32'd6);
        repeat (r) step();
        pipe_wr_req = 1'b1;
        repeat (3) step();
        pipe_wr_req = 1'b0;
        wait_idle();

        // start while busy must be ignored
        issue(32'd123, 32'h8000_0003, 5'd5);
        repeat (9) step();
        start = 1'b1;
        op_a  = $urandom;
        op_b  = $urandom;
        rd    = 5'd1;
        step();
        start = 1'b0;
        wait_idle();

        // reset in the middle of RUN aborts with no write
        issue(32'd55, 32'h8000_0001, 5'd7);
        repeat (11) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_zero("abort");
        issue(32'd13, 32'd11, 5'd4);
        wait_idle();

        // short multipliers and r0 destination
        issue(32'd9, 32'd5, 5'd2);
        wait_idle();
        issue(32'd77, 32'd0, 5'd0);
        wait_idle();

        // randomized operations with random write-port contention
        pipe_rand = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = WIDTH'($urandom_range(0, 255));
                2:       b = '1;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            issue(a, b, AW'($urandom));
            wait_idle();
        end
        pipe_rand   = 1'b0;
        pipe_wr_req = 1'b0;
        repeat (3) step();

        check("scoreboard_drained", 64'(exp_q.size()), 0);
        check("no_pending_op", pend, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
